// File: rtl/factorize_if.sv
// Handshake bundle between a factorize_engine and its requester/consumer.
interface factorize_if #(parameter int WIDTH = 8);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] n_in;
    logic             busy;
    logic [WIDTH-1:0] factor;
    logic             factor_valid;
    logic             factor_ready;
    logic             factor_last;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] num_factors;

    modport master (
        output start, n_in, factor_ready,
        input  busy, factor, factor_valid, factor_last, done, error, num_factors
    );

    modport slave (
        input  start, n_in, factor_ready,
        output busy, factor, factor_valid, factor_last, done, error, num_factors
    );
endinterface

// File: rtl/factorize_engine.sv
// Prime factorization by trial division, streaming factors in non-decreasing order.
//   state  | meaning
//   IDLE   | waiting for start
//   DIVIDE | restoring divide n / d, one quotient bit per cycle
//   DECIDE | classify remainder: factor found, n prime, or next divisor
//   EMIT   | factor offered, waiting for factor_ready
//   FINISH | one-cycle done pulse
module factorize_engine #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    factorize_if.slave  bus
);
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int STEP_W = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, DIVIDE, DECIDE, EMIT, FINISH} state_t;

    state_t            state;
    logic [WIDTH-1:0]  n_reg;
    logic [WIDTH-1:0]  d_reg;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  rem;
    logic [STEP_W-1:0] step;
    logic [WIDTH:0]    rem_shift;
    logic [WIDTH:0]    diff;

    // The remainder stays below d, so a negative trial difference always sets the top bit.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        diff      = rem_shift - {1'b0, d_reg};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            n_reg            <= '0;
            d_reg            <= '0;
            quo              <= '0;
            rem              <= '0;
            step             <= '0;
            bus.busy         <= 1'b0;
            bus.factor       <= '0;
            bus.factor_valid <= 1'b0;
            bus.factor_last  <= 1'b0;
            bus.done         <= 1'b0;
            bus.error        <= 1'b0;
            bus.num_factors  <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_reg           <= bus.n_in;
                        d_reg           <= WIDTH'(2);
                        bus.num_factors <= '0;
                        bus.error       <= (bus.n_in == '0);
                        bus.busy        <= 1'b1;
                        if (bus.n_in <= WIDTH'(1)) begin
                            bus.done <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            quo   <= bus.n_in;
                            rem   <= '0;
                            step  <= STEP_W'(WIDTH - 1);
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (!diff[WIDTH]) begin
                        rem <= diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    if (step == '0) begin
                        state <= DECIDE;
                    end else begin
                        step <= step - STEP_W'(1);
                    end
                end
                DECIDE: begin
                    if (rem == '0) begin
                        bus.factor       <= d_reg;
                        bus.factor_last  <= (quo == WIDTH'(1));
                        bus.factor_valid <= 1'b1;
                        n_reg            <= quo;
                        state            <= EMIT;
                    end else if (quo < d_reg) begin
                        bus.factor       <= n_reg;
                        bus.factor_last  <= 1'b1;
                        bus.factor_valid <= 1'b1;
                        state            <= EMIT;
                    end else begin
                        d_reg <= d_reg + WIDTH'(1);
                        quo   <= n_reg;
                        rem   <= '0;
                        step  <= STEP_W'(WIDTH - 1);
                        state <= DIVIDE;
                    end
                end
                EMIT: begin
                    if (bus.factor_ready) begin
                        bus.factor_valid <= 1'b0;
                        bus.num_factors  <= bus.num_factors + CNT_W'(1);
                        if (bus.factor_last) begin
                            bus.done <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            // Same d again: the divisor may repeat in the factorization.
                            quo   <= n_reg;
                            rem   <= '0;
                            step  <= STEP_W'(WIDTH - 1);
                            state <= DIVIDE;
                        end
                    end
                end
                FINISH: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/factorize_engine.md
FACTORIZE_ENGINE -- requirements
Module: factorize_engine

Interface
REQ-001 Parameter: WIDTH, default 8, operand and factor width in bits (legal range 4..16).
REQ-002 Parameter (localparam): CNT_W = $clog2(WIDTH+1), width of the factor count.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to factorize n_in; sampled only in IDLE.
REQ-006 n_in  input  WIDTH  unsigned operand, captured on an accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start until the cycle done is high.
REQ-008 factor  output  WIDTH  current prime factor.
REQ-009 factor_valid  output  1  factor is valid.
REQ-010 factor_ready  input  1  consumer accepts factor.
REQ-011 factor_last  output  1  qualifies factor_valid; marks the final factor.
REQ-012 done  output  1  one-cycle pulse at completion.
REQ-013 error  output  1  high with done when the operand was 0; held until the next accepted start.
REQ-014 num_factors  output  CNT_W  factors emitted for the current or last operand, with multiplicity.

Function
REQ-015 States: IDLE, DIVIDE, DECIDE, EMIT, FINISH.
REQ-016 IDLE + start: capture n = n_in, set d = 2, num_factors = 0, clear error.
- n_in == 0: go to FINISH with error = 1.
- n_in == 1: go to FINISH with error = 0.
- Otherwise: go to DIVIDE.
REQ-017 start outside IDLE is ignored, with no effect on any state or output.
REQ-018 DIVIDE: a restoring shift-subtract divider computes q = n / d and r = n % d in exactly WIDTH cycles, then goes to DECIDE; the block contains no multiplier or combinational divider.
REQ-019 DECIDE, one cycle, first matching rule applies:
- r == 0: factor = d, factor_last = (q == 1), n = q, go to EMIT.
- q < d: factor = n, factor_last = 1, go to EMIT (n is prime).
- Otherwise: d = d + 1, go to DIVIDE.
REQ-020 EMIT: factor_valid = 1; factor and factor_last stay stable while factor_ready is low.
REQ-021 EMIT handshake: when factor_valid and factor_ready are both high, num_factors increments; go to FINISH if factor_last, else to DIVIDE with d unchanged (repeated factors).
REQ-022 FINISH: done = 1 for exactly one cycle, then IDLE; num_factors and error hold until the next accepted start.
REQ-023 factor_valid is low in every state except EMIT.
REQ-024 Factors are emitted in non-decreasing order; their product equals the captured operand.
REQ-025 d never exceeds 2^ceil(WIDTH/2)+1, so d and all arithmetic fit in WIDTH bits without overflow.
REQ-026 Latency per trial divisor: WIDTH+1 cycles excluding EMIT time.

Reset
REQ-027 reset forces IDLE on the next edge, including in the middle of DIVIDE or EMIT; any in-flight factor is dropped with no done pulse.
REQ-028 After reset: busy = 0, factor_valid = 0, factor_last = 0, done = 0, error = 0, factor = 0, num_factors = 0.
REQ-029 A start asserted during the reset cycle is not accepted.

Verification
REQ-030 Operand 60, factor_ready = 1 -> factors 2, 2, 3, 5; factor_last only on 5; one done pulse; num_factors = 4; error = 0.
REQ-031 Operand 251 -> single factor 251 with factor_last = 1, num_factors = 1. Operand 255 -> factors 3, 5, 17.
REQ-032 Operand 0 -> no factor_valid; done and error within 2 cycles; num_factors = 0. Operand 1 -> done, error = 0, num_factors = 0.
REQ-033 Operand 12, factor_ready held low 5 cycles at each factor -> factor 2 stable through the stall; sequence 2, 2, 3 unchanged; start pulsed mid-run is ignored.
REQ-034 reset asserted mid-DIVIDE on operand 221 -> next cycle busy = 0, factor_valid = 0, no done pulse; a new start with operand 221 then yields 13, 17.
REQ-035 WIDTH = 12, operand 4093 (prime) -> single factor 4093, factor_last = 1, no overflow.
